// File: rtl/priority_coder_stream.sv
// priority_coder_stream
// Captures a DATA_W-bit request vector through a valid/ready handshake and
// reports the index of every set bit, one index per output handshake.
// MSB_FIRST selects whether the lowest or highest set index goes first.
// Optional feature macro: PRIORITY_CODER_STREAM_COUNT_EN
//   adds out_remain (popcount of the unreported bits) and drop_cnt
//   (saturating count of accepted all-zero vectors).
module priority_coder_stream #(
  parameter int DATA_W    = 16,
  parameter int POS_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_last,
  output logic              busy
`ifdef PRIORITY_CODER_STREAM_COUNT_EN
  ,
  output logic [POS_W:0]    out_remain,
  output logic [7:0]        drop_cnt
`endif
);

  // Every index up to DATA_W-1 must fit in out_pos.
  generate
    if (DATA_W < 2 || (2 ** POS_W) < DATA_W) begin : g_bad_params
      $error("priority_coder_stream: need DATA_W >= 2 and 2**POS_W >= DATA_W");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_pending;
  logic [POS_W-1:0]    w_sel_idx;
  logic [DATA_W-1:0]   w_sel_mask;
  logic                w_one_left;
  logic                w_out_hs;
  logic                w_in_accept;

  // Index of the bit to report next; a later hit in the loop overrides an
  // earlier one, so the loop direction sets which end wins.
  function automatic logic [POS_W-1:0] f_sel_idx(input logic [DATA_W-1:0] vec);
    logic [POS_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (vec[i]) idx = POS_W'(i);
      end
    end else begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = POS_W'(i);
      end
    end
    return idx;
  endfunction

`ifdef PRIORITY_CODER_STREAM_COUNT_EN
  // Number of set bits, sized so DATA_W itself is representable.
  function automatic logic [POS_W:0] f_popcount(input logic [DATA_W-1:0] vec);
    logic [POS_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + (POS_W + 1)'(vec[i]);
    end
    return cnt;
  endfunction
`endif

  assign w_sel_idx   = f_sel_idx(r_pending);
  // A vector with exactly one bit set clears to zero when its lowest bit is removed.
  assign w_one_left  = (r_pending != '0) && ((r_pending & (r_pending - DATA_W'(1))) == '0);
  assign w_out_hs    = (r_state == S_EMIT) && out_ready;
  assign w_in_accept = (r_state == S_IDLE) && in_valid;

  // One-hot mask of the reported bit, used to clear it on handshake.
  always_comb begin
    w_sel_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_sel_mask[i] = (POS_W'(i) == w_sel_idx);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: leave IDLE only for a non-empty vector, leave EMIT on the final beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid && (in_data != '0)) w_state_nxt = S_EMIT;
      S_EMIT: if (out_ready && w_one_left)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending bits: load on accept (a zero vector loads zero), drop the reported bit on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else if (w_in_accept) begin
      r_pending <= in_data;
    end else if (w_out_hs) begin
      r_pending <= r_pending & ~w_sel_mask;
    end
  end

  // FSM outputs, decoded from registered state and pending bits only.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_EMIT);
    busy      = (r_state == S_EMIT);
    out_pos   = (r_state == S_EMIT) ? w_sel_idx : '0;
    out_last  = (r_state == S_EMIT) && w_one_left;
  end

`ifdef PRIORITY_CODER_STREAM_COUNT_EN
  logic [7:0] r_drop_cnt;

  // Count accepted all-zero vectors, holding at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_in_accept && (in_data == '0) && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt   = r_drop_cnt;
  // Pending is zero in IDLE, so this reads 0 there without extra gating.
  assign out_remain = f_popcount(r_pending);
`endif

endmodule
